// File: rtl/sram_slot_arbiter.sv
// Time-slot arbiter sharing one frame-buffer SRAM between the display prefetch FIFO (read slot)
// and the frame writer (write slot), with all SRAM strobes and status outputs registered.
module sram_slot_arbiter #(
   parameter int unsigned SLOT_LEN   = 8,
   parameter int unsigned RD_PHASE   = 0,
   parameter int unsigned WR_PHASE   = 4,
   parameter int unsigned COLS       = 100,
   parameter int unsigned ROWS       = 600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic [9:0]  disp_line,
   input  logic        pix_rd,
   output logic [5:0]  rd_data,
   output logic        fifo_empty,
   output logic        underrun,
   input  logic        wr_hold,
   output logic        write,
   output logic [17:0] sram_addr,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n,
   output logic        sram_lb_n,
   input  logic [15:0] sram_dq_in
);

   localparam int unsigned SW = $clog2(SLOT_LEN);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [SW-1:0] P_LAST = SW'(SLOT_LEN - 1);
   localparam logic [SW-1:0] P_RD   = SW'(RD_PHASE);
   localparam logic [SW-1:0] P_CAP  = SW'((RD_PHASE + 1) % SLOT_LEN);
   localparam logic [SW-1:0] P_WR   = SW'(WR_PHASE);
   localparam logic [6:0]    C_LAST = 7'(COLS - 1);
   localparam logic [9:0]    R_LAST = 10'(ROWS - 1);
   localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {FETCH_IDLE, FETCH_ARMED, FETCH_BUSY} fetch_t;

   fetch_t        r_fetch;
   logic [SW-1:0] r_slot;
   logic [9:0]    r_rd_row;
   logic [6:0]    r_rd_col;
   logic [9:0]    r_wr_row;
   logic [6:0]    r_wr_col;
   logic [5:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;

   logic [SW-1:0] w_slot_nxt;
   logic          w_push;
   logic          w_pop;
   logic          w_launch;
   logic          w_hold_rd;
   logic          w_wr;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_cnt_left;
   logic [AW-1:0] w_rp_nxt;
   logic [5:0]    w_head_nxt;
   logic          w_unused_dq;

   assign w_unused_dq = ^sram_dq_in[15:6];

   // Strobes are registered, so slot decisions look at the phase the next clock will be in.
   always_comb begin
      w_slot_nxt = (r_slot == P_LAST) ? '0 : r_slot + 1'b1;
      w_pop      = pix_rd && (r_count != '0);
      w_push     = (r_fetch == FETCH_BUSY) && (r_slot == P_CAP) && !line_start;
      w_launch   = !line_start && (w_slot_nxt == P_RD) && (r_fetch == FETCH_ARMED)
                   && (r_count != C_FULL);
      w_hold_rd  = !line_start && (w_slot_nxt == P_CAP) && (r_fetch == FETCH_BUSY);
      w_wr       = (w_slot_nxt == P_WR) && !wr_hold;
      w_cnt_left = r_count - CW'(w_pop);
      w_cnt_nxt  = line_start ? '0 : w_cnt_left + CW'(w_push);
      w_rp_nxt   = line_start ? '0 : r_rp + AW'(w_pop);
      // A word pushed into an otherwise empty FIFO becomes the new head directly.
      if (w_cnt_nxt == '0)
         w_head_nxt = '0;
      else if (w_cnt_left == '0)
         w_head_nxt = sram_dq_in[5:0];
      else
         w_head_nxt = r_mem[w_rp_nxt];
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wp] <= sram_dq_in[5:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_slot     <= '0;
         r_fetch    <= FETCH_IDLE;
         r_rd_row   <= '0;
         r_rd_col   <= '0;
         r_wr_row   <= '0;
         r_wr_col   <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         rd_data    <= '0;
         fifo_empty <= 1'b1;
         underrun   <= 1'b0;
         write      <= 1'b0;
         sram_addr  <= '0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         sram_lb_n  <= 1'b1;
      end else begin
         r_slot    <= w_slot_nxt;
         write     <= 1'b0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_lb_n <= 1'b1;

         if (w_launch) begin
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_lb_n <= 1'b0;
            sram_addr <= {1'b0, r_rd_row, r_rd_col};
         end else if (w_hold_rd) begin
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_lb_n <= 1'b0;
         end

         if (w_wr) begin
            write     <= 1'b1;
            sram_ce_n <= 1'b0;
            sram_we_n <= 1'b0;
            sram_lb_n <= 1'b0;
            sram_oe_n <= 1'b1;
            sram_addr <= {1'b0, r_wr_row, r_wr_col};
            if (r_wr_col == C_LAST) begin
               r_wr_col <= '0;
               r_wr_row <= (r_wr_row == R_LAST) ? '0 : r_wr_row + 10'd1;
            end else begin
               r_wr_col <= r_wr_col + 7'd1;
            end
         end

         r_count    <= w_cnt_nxt;
         r_rp       <= w_rp_nxt;
         fifo_empty <= (w_cnt_nxt == '0);
         rd_data    <= w_head_nxt;
         if (pix_rd && (r_count == '0))
            underrun <= 1'b1;

         if (line_start) begin
            r_fetch  <= FETCH_ARMED;
            r_rd_row <= disp_line;
            r_rd_col <= '0;
            r_wp     <= '0;
         end else begin
            if (w_push)
               r_wp <= r_wp + 1'b1;
            if (w_launch)
               r_fetch <= FETCH_BUSY;
            else if (r_fetch == FETCH_BUSY && r_slot == P_CAP) begin
               r_rd_col <= r_rd_col + 7'd1;
               r_fetch  <= (r_rd_col == C_LAST) ? FETCH_IDLE : FETCH_ARMED;
            end
         end
      end
   end

endmodule
